// File: rtl/rng_request_scheduler_pkg.sv
// Shared types and defaults for the RNG request scheduler.
//   - sched_state_e : scheduler FSM states
//   - req_kind_e    : RDRAND / RDSEED request kinds
//   - len_decode()  : 2-bit length code -> byte count (2/4/8/16)
//   - *_DEF         : default widths / intervals used by the top and interface
package rng_request_scheduler_pkg;

    localparam int BLOCK_BITS_DEF      = 128;
    localparam int SEED_BITS_DEF       = 256;
    localparam int RESEED_INTERVAL_DEF = 511;
    localparam int CNT_W_DEF           = 9;
    localparam int TIMEOUT_CYC_DEF     = 4096;

    typedef enum logic [3:0] {
        UNINST,
        INST_WAIT,
        IDLE,
        RESEED_WAIT,
        RESEED_DONE,
        GEN_ISSUE,
        GEN_WAIT,
        SEED_WAIT,
        SHIFT
    } sched_state_e;

    typedef enum logic {
        REQ_RDRAND = 1'b0,
        REQ_RDSEED = 1'b1
    } req_kind_e;

    // bytes = 2 << code; the largest value (16) still fits in the 5-bit byte counter
    function automatic logic [4:0] len_decode(input logic [1:0] code);
        return 5'd2 << code;
    endfunction

endpackage

// File: rtl/rng_request_scheduler_if.sv
// Signal bundle between the scheduler and its neighbours (CPU pins,
// conditioner, drbg_0).
//   master : scheduler side (drives rand_*, busy_o, rdseed_ready_o, drbg_* commands)
//   slave  : environment side (drives requests, seed, DRBG status/data)
interface rng_request_scheduler_if
    import rng_request_scheduler_pkg::*;
#(
    parameter int BLOCK_BITS = BLOCK_BITS_DEF,
    parameter int SEED_BITS  = SEED_BITS_DEF
);
    // CPU pins
    logic                  rand_req;
    logic [2:0]            rand_req_type;
    logic [7:0]            rand_byte;
    logic                  rand_valid;
    logic                  busy_o;
    logic                  rand_err;
    // conditioner
    logic [SEED_BITS-1:0]  seed_i;
    logic                  drbg_seed_valid_i;
    logic                  rdseed_valid_i;
    logic                  rdseed_ready_o;
    // DRBG
    logic                  drbg_instantiate_o;
    logic                  drbg_reseed_o;
    logic                  drbg_generate_o;
    logic [7:0]            drbg_num_blocks_o;
    logic                  drbg_done_i;
    logic                  drbg_block_valid_i;
    logic [BLOCK_BITS-1:0] drbg_block_i;

    modport master (
        input  rand_req, rand_req_type, seed_i, drbg_seed_valid_i, rdseed_valid_i,
               drbg_done_i, drbg_block_valid_i, drbg_block_i,
        output rand_byte, rand_valid, busy_o, rand_err, rdseed_ready_o,
               drbg_instantiate_o, drbg_reseed_o, drbg_generate_o, drbg_num_blocks_o
    );

    modport slave (
        output rand_req, rand_req_type, seed_i, drbg_seed_valid_i, rdseed_valid_i,
               drbg_done_i, drbg_block_valid_i, drbg_block_i,
        input  rand_byte, rand_valid, busy_o, rand_err, rdseed_ready_o,
               drbg_instantiate_o, drbg_reseed_o, drbg_generate_o, drbg_num_blocks_o
    );

endinterface

// File: rtl/rng_request_scheduler_byte_serializer.sv
// Loads a BLOCK_BITS word and streams n_i bytes out, LSB byte first.
//   clk, rst : clock, async active-high reset
//   load_i   : capture data_i and clear the byte counter
//   data_i   : word to serialize
//   n_i      : number of bytes to emit (1..16)
//   en_i     : streaming enabled (one byte per cycle while bytes remain)
//   valid_o  : byte_o holds a live byte this cycle
//   byte_o   : current byte (0 when not valid)
//   last_o   : the byte on byte_o is the final one
//   empty_o  : all n_i bytes have been emitted
module rng_request_scheduler_byte_serializer #(
    parameter int BLOCK_BITS = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [BLOCK_BITS-1:0] data_i,
    input  logic [4:0]            n_i,
    input  logic                  en_i,
    output logic                  valid_o,
    output logic [7:0]            byte_o,
    output logic                  last_o,
    output logic                  empty_o
);

    logic [BLOCK_BITS-1:0] shreg_q, shreg_d;
    logic [4:0]            cnt_q, cnt_d;

    assign valid_o = en_i && (cnt_q < n_i);
    assign byte_o  = valid_o ? shreg_q[7:0] : 8'h00;
    assign last_o  = valid_o && (cnt_q == n_i - 5'd1);
    assign empty_o = (cnt_q >= n_i);

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            shreg_d = data_i;
            cnt_d   = '0;
        end else if (valid_o) begin
            shreg_d = shreg_q >> 8;
            cnt_d   = cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/rng_request_scheduler.sv
// RNG request scheduler: sequences drbg_0 (instantiate / reseed / generate),
// enforces the reseed interval, and serves RDRAND (DRBG block) and RDSEED
// (raw conditioner seed) requests as a byte stream on rand_byte/rand_valid.
// Ports:
//   clk, rst : system clock, async active-high reset
//   bus      : rng_request_scheduler_if.master (CPU pins, conditioner, DRBG)
// Optional build macro RNG_SCHED_TIMEOUT_EN adds a TIMEOUT_CYC watchdog on
// every wait state that pulses rand_err and abandons the request; without it
// rand_err is tied to 0.
module rng_request_scheduler
    import rng_request_scheduler_pkg::*;
#(
    parameter int BLOCK_BITS      = BLOCK_BITS_DEF,
    parameter int SEED_BITS       = SEED_BITS_DEF,
    parameter int RESEED_INTERVAL = RESEED_INTERVAL_DEF,
    parameter int CNT_W           = CNT_W_DEF,
    parameter int TIMEOUT_CYC     = TIMEOUT_CYC_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    rng_request_scheduler_if.master bus
);

    localparam logic [CNT_W-1:0] RESEED_LIM = CNT_W'(RESEED_INTERVAL);

    sched_state_e     state_q, state_d;
    req_kind_e        kind_q, kind_d;
    logic [4:0]       n_q, n_d;
    logic [CNT_W-1:0] gen_cnt_q, gen_cnt_d;
    logic             done_seen_q, done_seen_d;

    logic             inst_pulse, reseed_pulse, err_pulse;
    logic             timeout;
    logic             ser_load, ser_valid, ser_last, ser_empty;
    logic [BLOCK_BITS-1:0] ser_data;
    logic [7:0]       ser_byte;

    // Seed bits above BLOCK_BITS are never forwarded.
    logic unused_seed_hi;
    assign unused_seed_hi = ^bus.seed_i[SEED_BITS-1:BLOCK_BITS];

`ifdef RNG_SCHED_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              in_wait;

    assign in_wait = state_q inside {INST_WAIT, RESEED_WAIT, RESEED_DONE, GEN_WAIT, SEED_WAIT};
    assign timeout = in_wait && (wait_cnt_q == WAIT_W'(TIMEOUT_CYC - 1));

    // Counts consecutive cycles spent in the same wait state; any state
    // change (including a timeout exit) restarts it.
    always_comb begin
        wait_cnt_d = '0;
        if (in_wait && (state_d == state_q))
            wait_cnt_d = wait_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wait_cnt_q <= '0;
        else     wait_cnt_q <= wait_cnt_d;
    end
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        n_d          = n_q;
        gen_cnt_d    = gen_cnt_q;
        done_seen_d  = done_seen_q;
        inst_pulse   = 1'b0;
        reseed_pulse = 1'b0;
        err_pulse    = 1'b0;
        ser_load     = 1'b0;
        ser_data     = bus.drbg_block_i;

        case (state_q)
            UNINST: begin
                if (bus.drbg_seed_valid_i) begin
                    inst_pulse = 1'b1;
                    state_d    = INST_WAIT;
                end
            end
            INST_WAIT: begin
                if (bus.drbg_done_i) begin
                    gen_cnt_d = '0;
                    state_d   = IDLE;
                end
            end
            IDLE: begin
                if (bus.rand_req) begin
                    kind_d      = req_kind_e'(bus.rand_req_type[2]);
                    n_d         = len_decode(bus.rand_req_type[1:0]);
                    done_seen_d = 1'b0;
                    if (kind_d == REQ_RDSEED)
                        state_d = SEED_WAIT;
                    else if (gen_cnt_q == RESEED_LIM)
                        state_d = RESEED_WAIT;
                    else
                        state_d = GEN_ISSUE;
                end
            end
            RESEED_WAIT: begin
                if (bus.drbg_seed_valid_i) begin
                    reseed_pulse = 1'b1;
                    state_d      = RESEED_DONE;
                end
            end
            RESEED_DONE: begin
                if (bus.drbg_done_i) begin
                    gen_cnt_d = '0;
                    state_d   = GEN_ISSUE;
                end
            end
            GEN_ISSUE: begin
                if (gen_cnt_q != RESEED_LIM)
                    gen_cnt_d = gen_cnt_q + 1'b1;
                done_seen_d = 1'b0;
                state_d     = GEN_WAIT;
            end
            GEN_WAIT: begin
                // The DRBG may finish before, with, or after the data beat;
                // remember it so SHIFT knows when the command has closed.
                if (bus.drbg_done_i)
                    done_seen_d = 1'b1;
                if (bus.drbg_block_valid_i) begin
                    ser_load = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SEED_WAIT: begin
                // rdseed_ready_o is high throughout this state
                if (bus.rdseed_valid_i) begin
                    ser_load = 1'b1;
                    ser_data = bus.seed_i[BLOCK_BITS-1:0];
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.drbg_done_i)
                    done_seen_d = 1'b1;
                if ((ser_last || ser_empty) &&
                    (kind_q == REQ_RDSEED || done_seen_q || bus.drbg_done_i))
                    state_d = IDLE;
            end
            default: state_d = UNINST;
        endcase

        // Watchdog only fires when the wait state made no progress this cycle.
        if (timeout && (state_d == state_q)) begin
            err_pulse = 1'b1;
            state_d   = (state_q == INST_WAIT) ? UNINST : IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= UNINST;
            kind_q      <= REQ_RDRAND;
            n_q         <= '0;
            gen_cnt_q   <= '0;
            done_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            n_q         <= n_d;
            gen_cnt_q   <= gen_cnt_d;
            done_seen_q <= done_seen_d;
        end
    end

    rng_request_scheduler_byte_serializer #(
        .BLOCK_BITS (BLOCK_BITS)
    ) u_ser (
        .clk     (clk),
        .rst     (rst),
        .load_i  (ser_load),
        .data_i  (ser_data),
        .n_i     (n_q),
        .en_i    (state_q == SHIFT),
        .valid_o (ser_valid),
        .byte_o  (ser_byte),
        .last_o  (ser_last),
        .empty_o (ser_empty)
    );

    assign bus.rand_valid         = ser_valid;
    assign bus.rand_byte          = ser_byte;
    assign bus.busy_o             = (state_q != IDLE);
    assign bus.rand_err           = err_pulse;
    assign bus.rdseed_ready_o     = (state_q == SEED_WAIT);
    // The instantiate pulse reacts combinationally to seed_valid in UNINST,
    // which is also the reset state; keep it quiet while reset is held.
    assign bus.drbg_instantiate_o = inst_pulse & ~rst;
    assign bus.drbg_reseed_o      = reseed_pulse;
    assign bus.drbg_generate_o    = (state_q == GEN_ISSUE);
    assign bus.drbg_num_blocks_o  = (state_q == GEN_ISSUE) ? 8'd1 : 8'd0;

endmodule

// File: tb/tb_rng_request_scheduler.sv
// Directed bench for rng_request_scheduler (RESEED_INTERVAL=3, TIMEOUT_CYC=16).
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
module tb_rng_request_scheduler;
    import rng_request_scheduler_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   n_inst = 0, n_reseed = 0, n_gen = 0;

    always #5 clk = ~clk;

    rng_request_scheduler_if #(.BLOCK_BITS(128), .SEED_BITS(256)) bus ();

    rng_request_scheduler #(
        .BLOCK_BITS      (128),
        .SEED_BITS       (256),
        .RESEED_INTERVAL (3),
        .CNT_W           (2),
        .TIMEOUT_CYC     (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk) begin
        if (bus.drbg_instantiate_o) n_inst   <= n_inst + 1;
        if (bus.drbg_reseed_o)      n_reseed <= n_reseed + 1;
        if (bus.drbg_generate_o)    n_gen    <= n_gen + 1;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One RDRAND transaction. reseed: expect a reseed handshake first.
    // done_early: drbg_done_i arrives with the data beat, otherwise after the
    // last byte. pulse_at: byte index during which rand_req is raised (-1 none).
    task automatic do_rdrand(input logic [1:0] code, input logic [127:0] blk,
                             input bit reseed, input bit done_early, input int pulse_at);
        int n;
        n = 2 << code;
        @(negedge clk); bus.rand_req = 1'b1; bus.rand_req_type = {1'b0, code};
        @(negedge clk); bus.rand_req = 1'b0;
        if (reseed) begin
            #1 chk1("reseed_hold", bus.drbg_reseed_o, 1'b0);
            chk1("gen_before_reseed", bus.drbg_generate_o, 1'b0);
            @(negedge clk); bus.drbg_seed_valid_i = 1'b1;
            #1 chk1("reseed_pulse", bus.drbg_reseed_o, 1'b1);
            chk1("gen_during_reseed", bus.drbg_generate_o, 1'b0);
            @(negedge clk); bus.drbg_seed_valid_i = 1'b0;
            #1 chk1("reseed_once", bus.drbg_reseed_o, 1'b0);
            bus.drbg_done_i = 1'b1;
            @(negedge clk); bus.drbg_done_i = 1'b0;
        end
        #1 chk1("gen_pulse", bus.drbg_generate_o, 1'b1);
        chk8("num_blocks", bus.drbg_num_blocks_o, 8'd1);
        chk1("err_quiet", bus.rand_err, 1'b0);
        @(negedge clk);
        #1 chk1("gen_single", bus.drbg_generate_o, 1'b0);
        chk8("num_blocks_idle", bus.drbg_num_blocks_o, 8'd0);
        bus.drbg_block_valid_i = 1'b1; bus.drbg_block_i = blk; bus.drbg_done_i = done_early;
        @(negedge clk); bus.drbg_block_valid_i = 1'b0; bus.drbg_done_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1 chk1("rdrand_valid", bus.rand_valid, 1'b1);
            chk8("rdrand_byte", bus.rand_byte, blk[8*i +: 8]);
            bus.rand_req = (i == pulse_at);
            @(negedge clk);
        end
        bus.rand_req = 1'b0;
        #1 chk1("rdrand_valid_end", bus.rand_valid, 1'b0);
        chk8("rdrand_byte_end", bus.rand_byte, 8'h00);
        if (!done_early) begin
            chk1("wait_done_busy", bus.busy_o, 1'b1);
            bus.drbg_done_i = 1'b1;
            @(negedge clk); bus.drbg_done_i = 1'b0;
            #1;
        end
        chk1("rdrand_idle", bus.busy_o, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, i0, r0;
        logic [255:0] seed;
        logic [127:0] blk8;

        rst = 1'b1;
        bus.rand_req = 1'b0; bus.rand_req_type = 3'b000; bus.seed_i = '0;
        bus.drbg_seed_valid_i = 1'b0; bus.rdseed_valid_i = 1'b0;
        bus.drbg_done_i = 1'b0; bus.drbg_block_valid_i = 1'b0; bus.drbg_block_i = '0;

        // ---- reset state
        repeat (2) @(negedge clk);
        #1 chk1("rst_busy", bus.busy_o, 1'b1);
        chk1("rst_valid", bus.rand_valid, 1'b0);
        chk8("rst_byte", bus.rand_byte, 8'h00);
        chk1("rst_ready", bus.rdseed_ready_o, 1'b0);
        chk1("rst_err", bus.rand_err, 1'b0);
        chk1("rst_gen", bus.drbg_generate_o, 1'b0);
        chk8("rst_state", 8'(dut.state_q), 8'(UNINST));
        chk8("rst_gen_cnt", 8'(dut.gen_cnt_q), 8'd0);
        bus.drbg_seed_valid_i = 1'b1;
        #1 chk1("rst_inst_gated", bus.drbg_instantiate_o, 1'b0);
        bus.drbg_seed_valid_i = 1'b0;

        // ---- instantiate: seed at cycle 3, done at cycle 10
        @(negedge clk); rst = 1'b0;                      // cycle 0
        repeat (2) @(negedge clk);                       // cycle 2
        #1 chk1("inst_idle", bus.drbg_instantiate_o, 1'b0);
        @(negedge clk); bus.drbg_seed_valid_i = 1'b1;    // cycle 3
        #1 chk1("inst_pulse", bus.drbg_instantiate_o, 1'b1);
        @(negedge clk); bus.drbg_seed_valid_i = 1'b0;    // cycle 4
        #1 chk1("inst_once", bus.drbg_instantiate_o, 1'b0);
        chk8("inst_wait_state", 8'(dut.state_q), 8'(INST_WAIT));
        repeat (6) @(negedge clk);                       // cycle 10
        bus.drbg_done_i = 1'b1;
        #1 chk1("inst_busy", bus.busy_o, 1'b1);
        @(negedge clk); bus.drbg_done_i = 1'b0;          // cycle 11
        #1 chk1("inst_ready", bus.busy_o, 1'b0);
        chk8("inst_count", 8'(n_inst), 8'd1);

        // ---- RDRAND 4 bytes (first generate of the interval)
        g0 = n_gen;
        do_rdrand(2'b01, 128'h0403_0201, 1'b0, 1'b1, -1);
        chk8("rdrand4_gen_count", 8'(n_gen - g0), 8'd1);
        chk8("gen_cnt_1", 8'(dut.gen_cnt_q), 8'd1);

        // ---- reseed interval: generates 2 and 3, then 4th forces reseed
        do_rdrand(2'b00, 128'h0000_C3A5, 1'b0, 1'b0, -1);
        do_rdrand(2'b00, 128'h0000_1E2D, 1'b0, 1'b1, -1);
        chk8("gen_cnt_3", 8'(dut.gen_cnt_q), 8'd3);
        r0 = n_reseed;
        do_rdrand(2'b00, 128'h0000_8877, 1'b1, 1'b1, -1);
        chk8("reseed_count", 8'(n_reseed - r0), 8'd1);
        chk8("gen_cnt_after_reseed", 8'(dut.gen_cnt_q), 8'd1);

        // ---- RDSEED 16 bytes, upper seed bits discarded
        for (int i = 0; i < 16; i++) seed[8*i +: 8] = 8'(i);
        seed[255:128] = 128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0;
        bus.seed_i = seed;
        g0 = n_gen; i0 = n_inst; r0 = n_reseed;
        @(negedge clk);
        #1 chk1("rdseed_ready_idle", bus.rdseed_ready_o, 1'b0);
        bus.rand_req = 1'b1; bus.rand_req_type = 3'b111;
        @(negedge clk); bus.rand_req = 1'b0;
        #1 chk1("rdseed_ready_wait", bus.rdseed_ready_o, 1'b1);
        chk8("seed_wait_state", 8'(dut.state_q), 8'(SEED_WAIT));
        @(negedge clk);
        #1 chk1("rdseed_ready_hold", bus.rdseed_ready_o, 1'b1);
        @(negedge clk); bus.rdseed_valid_i = 1'b1;
        #1 chk1("rdseed_ready_hs", bus.rdseed_ready_o, 1'b1);
        @(negedge clk); bus.rdseed_valid_i = 1'b0;
        #1 chk1("rdseed_ready_shift", bus.rdseed_ready_o, 1'b0);
        for (int i = 0; i < 16; i++) begin
            #1 chk1("rdseed_valid", bus.rand_valid, 1'b1);
            chk8("rdseed_byte", bus.rand_byte, 8'(i));
            @(negedge clk);
        end
        #1 chk1("rdseed_valid_end", bus.rand_valid, 1'b0);
        chk1("rdseed_idle", bus.busy_o, 1'b0);
        chk8("rdseed_no_drbg", 8'((n_gen - g0) + (n_inst - i0) + (n_reseed - r0)), 8'd0);

        // ---- rand_req during the last SHIFT byte is ignored
        g0 = n_gen;
        do_rdrand(2'b10, 128'h8877_6655_4433_2211, 1'b0, 1'b1, 7);
        @(negedge clk);
        #1 chk1("ignored_req_idle", bus.busy_o, 1'b0);
        chk1("ignored_req_no_bytes", bus.rand_valid, 1'b0);
        chk8("ignored_req_gen", 8'(n_gen - g0), 8'd1);

        // ---- reset during byte 2 of 8
        blk8 = 128'h1817_1615_1413_1211;
        @(negedge clk); bus.rand_req = 1'b1; bus.rand_req_type = 3'b010;
        @(negedge clk); bus.rand_req = 1'b0;
        #1 chk1("abort_gen", bus.drbg_generate_o, 1'b1);
        @(negedge clk);
        bus.drbg_block_valid_i = 1'b1; bus.drbg_block_i = blk8; bus.drbg_done_i = 1'b1;
        @(negedge clk); bus.drbg_block_valid_i = 1'b0; bus.drbg_done_i = 1'b0;
        #1 chk8("abort_b0", bus.rand_byte, 8'h11);
        @(negedge clk);
        #1 chk8("abort_b1", bus.rand_byte, 8'h12);
        @(negedge clk);
        #1 chk8("abort_b2", bus.rand_byte, 8'h13);
        chk1("abort_b2_valid", bus.rand_valid, 1'b1);
        rst = 1'b1;
        #1 chk1("abort_valid", bus.rand_valid, 1'b0);
        chk8("abort_byte", bus.rand_byte, 8'h00);
        chk1("abort_busy", bus.busy_o, 1'b1);
        chk8("abort_state", 8'(dut.state_q), 8'(UNINST));
        chk8("abort_gen_cnt", 8'(dut.gen_cnt_q), 8'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); bus.drbg_seed_valid_i = 1'b1;
        #1 chk1("reinst_pulse", bus.drbg_instantiate_o, 1'b1);
        @(negedge clk); bus.drbg_seed_valid_i = 1'b0; bus.drbg_done_i = 1'b1;
        @(negedge clk); bus.drbg_done_i = 1'b0;
        #1 chk1("reinst_idle", bus.busy_o, 1'b0);
        do_rdrand(2'b00, 128'h0000_EE5A, 1'b0, 1'b1, -1);
        chk8("reinst_gen_cnt", 8'(dut.gen_cnt_q), 8'd1);

`ifdef RNG_SCHED_TIMEOUT_EN
        // ---- watchdog: block never arrives
        @(negedge clk); bus.rand_req = 1'b1; bus.rand_req_type = 3'b000;
        @(negedge clk); bus.rand_req = 1'b0;
        #1 chk1("to_gen", bus.drbg_generate_o, 1'b1);
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            #1 chk1("to_err_early", bus.rand_err, 1'b0);
        end
        @(negedge clk);
        #1 chk1("to_err_pulse", bus.rand_err, 1'b1);
        chk1("to_no_bytes", bus.rand_valid, 1'b0);
        @(negedge clk);
        #1 chk1("to_err_single", bus.rand_err, 1'b0);
        chk1("to_idle", bus.busy_o, 1'b0);
        chk1("to_valid", bus.rand_valid, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
